// File: rtl/serial_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_ctrl_pkg
//  Purpose  : Shared encodings for the bit-serial ALU front end.
//             Holds the operation codes seen on the op port and the
//             controller state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package serial_alu_ctrl_pkg;

  // Operation codes carried on the op port and into the 1-bit cell
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_alu_ctrl_bit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_bit
//  Purpose  : Purely combinational 1-bit calculation cell.
//             B is optionally inverted before use.  Logic operations pass
//             the carry through unchanged; ADD produces a full-adder sum
//             and majority carry.
//  Ports    : a, b     operand bits
//             inv_b    invert b before use
//             c        carry in
//             op       operation code (OP_AND/OP_OR/OP_XOR/OP_ADD)
//             r        result bit
//             cnext    carry out
//  Revision : 1.0  initial release
// ============================================================================
module serial_alu_bit
  import serial_alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       inv_b,
  input  logic       c,
  input  logic [1:0] op,
  output logic       r,
  output logic       cnext
);

  logic w_bb;

  assign w_bb = b ^ inv_b;

  always_comb begin
    r     = 1'b0;
    cnext = c;
    case (op)
      OP_AND:  r = a & w_bb;
      OP_OR:   r = a | w_bb;
      OP_XOR:  r = a ^ w_bb;
      default: begin
        r     = a ^ w_bb ^ c;
        cnext = (a & w_bb) | (a & c) | (w_bb & c);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_ctrl
//  Purpose  : Bit-serial ALU controller.  Captures two WIDTH-bit operands on
//             an accepted start, feeds the 1-bit cell LSB first with the
//             cell's carry looped back through a flip-flop, assembles the
//             parallel result and reports carry-out, signed overflow and a
//             one-cycle done pulse.
//  Ports    : clk, rst_n            clock, synchronous active-low reset
//             start                 request pulse, accepted only in IDLE
//             a, b, op, inv_b, cin  operation, captured on accept
//             busy                  high in RUN and DONE
//             done                  one-cycle completion pulse
//             result, cout, ovf     registered results, valid from done on
//  Revision : 1.0  initial release
// ============================================================================
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             inv_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [1:0]       r_op;
  logic             r_inv;
  logic             r_c;

  logic             w_r;
  logic             w_cnext;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_last;

  serial_alu_bit u_bit (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .inv_b (r_inv),
    .c     (r_c),
    .op    (r_op),
    .r     (w_r),
    .cnext (w_cnext)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB
  assign w_sh_next = {w_r, r_sh[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_op    <= OP_AND;
      r_inv   <= 1'b0;
      r_c     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_inv   <= inv_b;
            r_c     <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_sh  <= w_sh_next;
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_cnext;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            result  <= w_sh_next;
            cout    <= w_cnext;
            // r_c here is the carry into the MSB
            ovf     <= (r_op == OP_ADD) ? (w_cnext ^ r_c) : 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_alu_ctrl
//  Purpose  : Self-checking bench for serial_alu_ctrl (WIDTH=8): directed
//             vector table, handshake and reset corner sequences, and
//             random operations against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_alu_ctrl;
  import serial_alu_ctrl_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             inv_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .inv_b  (inv_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [1:0]       vop;
    logic             vinv;
    logic             vcin;
    logic [WIDTH-1:0] er;
    logic             ec;
    logic             eo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no bit-serial modelling
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic [1:0] mop, input logic minv, input logic mcin,
                       output logic [WIDTH-1:0] mr, output logic mco, output logic mov);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    bb  = minv ? ~mb : mb;
    mco = mcin;
    mov = 1'b0;
    case (mop)
      OP_AND:  mr = ma & bb;
      OP_OR:   mr = ma | bb;
      OP_XOR:  mr = ma ^ bb;
      default: begin
        sum = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, mcin};
        mr  = sum[WIDTH-1:0];
        mco = sum[WIDTH];
        mov = (ma[WIDTH-1] == bb[WIDTH-1]) && (mr[WIDTH-1] != ma[WIDTH-1]);
      end
    endcase
  endtask

  // Issue one operation from an idle DUT and check latency and outputs
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [1:0] top, input logic tinv, input logic tcin,
                        input logic [WIDTH-1:0] er, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a = ta; b = tb; op = top; inv_b = tinv; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble operands after accept; they must have no effect
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = 2'($urandom); inv_b = ~tinv; cin = ~tcin;
    n = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 3 * WIDTH) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(WIDTH + 1));
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin : main
    logic [WIDTH-1:0] rr, ra, rb;
    logic [1:0]       rop;
    logic             rinv, rcin, rco, rov;
    int               dones, dn, d1, d2, cnt;
    logic [WIDTH-1:0] dres;

    vecs[0] = '{8'h3C, 8'h0F, OP_ADD, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, OP_ADD, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 8'h05, OP_ADD, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[5] = '{8'hF0, 8'h3C, OP_AND, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0};
    vecs[6] = '{8'hF0, 8'h3C, OP_OR,  1'b0, 1'b0, 8'hFC, 1'b0, 1'b0};
    vecs[7] = '{8'hF0, 8'h3C, OP_XOR, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b0};
    vecs[8] = '{8'hF0, 8'h3C, OP_XOR, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0};
    vecs[9] = '{8'h80, 8'h80, OP_ADD, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = OP_AND; inv_b = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf",  32'(ovf), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].vinv,
             vecs[i].vcin, vecs[i].er, vecs[i].ec, vecs[i].eo);

    // start pulsed while busy is ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; op = OP_ADD; inv_b = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; dn = 0; dres = '0;
    for (int n = 1; n <= 24; n++) begin
      if (n == 3) begin a = 8'hAA; b = 8'h55; op = OP_XOR; start = 1'b1; end
      if (n == 4) start = 1'b0;
      if (done) begin dones++; dn = n; dres = result; end
      @(negedge clk);
    end
    chk("ign_count", 32'(dones), 32'd1);
    chk("ign_lat",   32'(dn), 32'(WIDTH + 1));
    chk("ign_res",   32'(dres), 32'h46);

    // start held high: back-to-back operations every WIDTH+2 cycles
    a = 8'h10; b = 8'h20; op = OP_ADD; inv_b = 1'b0; cin = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = n;
        else if (d2 == 0) d2 = n;
      end
    end
    start = 1'b0;
    chk("held_first", 32'(d1), 32'(WIDTH + 1));
    chk("held_gap",   32'(d2 - d1), 32'(WIDTH + 2));
    cnt = 0;
    while (busy && cnt < 40) begin @(negedge clk); cnt++; end
    chk("held_drain", 32'(busy), 32'd0);
    chk("held_res",   32'(result), 32'h30);

    // reset asserted mid-run abandons the operation
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; op = OP_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 4) rst_n = 1'b0;
      if (n == 5) begin
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_res",  32'(result), 32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        chk("mrst_ovf",  32'(ovf), 32'd0);
        rst_n = 1'b1;
      end
      if (done) dones++;
      @(negedge clk);
    end
    chk("mrst_nodone", 32'(dones), 32'd0);
    run_op("post_rst", 8'h3C, 8'h0F, OP_ADD, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);

    // random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rop  = 2'($urandom_range(0, 3));
      rinv = 1'($urandom);
      rcin = 1'($urandom);
      model(ra, rb, rop, rinv, rcin, rr, rco, rov);
      run_op($sformatf("rnd%0d", i), ra, rb, rop, rinv, rcin, rr, rco, rov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
